// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, lane masks.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_BYTE = 4'b0001;
    localparam logic [3:0] LANE_HALF = 4'b0011;
    localparam logic [3:0] LANE_WORD = 4'b1111;

    // Low address bits rounded down to the natural alignment of the access size.
    function automatic logic [1:0] natural_lo(input size_e size, input logic [1:0] lo);
        logic [1:0] r;
        case (size)
            SIZE_BYTE: r = lo;
            SIZE_HALF: r = {lo[1], 1'b0};
            default:   r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables/replication and load extract/extend.
// DMEM_MISALIGN_ERR_EN: flag misaligned or reserved-size accesses instead of aligning them.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    size_e       w_size;
    logic [1:0]  w_lo;
    logic [31:0] w_shift;

    always_comb begin
        w_size = size_e'(i_size);
        w_lo   = i_addr_lo;
        o_err  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        o_err = (w_size == SIZE_RSVD)
             || ((w_size == SIZE_HALF) && i_addr_lo[0])
             || ((w_size == SIZE_WORD) && (i_addr_lo != 2'b00));
`else
        if (w_size == SIZE_RSVD) begin
            w_size = SIZE_WORD;
        end
        w_lo = natural_lo(w_size, i_addr_lo);
`endif
    end

    always_comb begin
        o_be    = LANE_NONE;
        o_wword = i_wdata;
        o_rdata = '0;
        w_shift = i_rword >> {w_lo, 3'b000};
        if (!o_err) begin
            case (w_size)
                SIZE_BYTE: begin
                    o_be    = LANE_BYTE << w_lo;
                    o_wword = {4{i_wdata[7:0]}};
                    o_rdata = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
                end
                SIZE_HALF: begin
                    o_be    = LANE_HALF << w_lo;
                    o_wword = {2{i_wdata[15:0]}};
                    o_rdata = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
                end
                default: begin
                    o_be    = LANE_WORD;
                    o_wword = i_wdata;
                    o_rdata = i_rword;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES delay, word SRAM, registered response.
// DMEM_MISALIGN_ERR_EN (in dmem_lane_align) enables rsp_err_o for misaligned/reserved accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned PRELOAD      = 0,
  parameter string       PRELOAD_FILE = "sim/dmem.hex"
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] r_mem [DEPTH];

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_cnt;

  logic                  r_wr;
  logic [1:0]            r_lo;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;

  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_commit;
  logic                  w_sel_wr;
  logic [1:0]            w_sel_lo;
  logic [ADDR_WIDTH-1:0] w_sel_widx;
  logic [1:0]            w_sel_size;
  logic                  w_sel_unsigned;
  logic [31:0]           w_sel_wdata;
  logic [31:0]           w_rword;
  logic [3:0]            w_be;
  logic [31:0]           w_wword;
  logic [31:0]           w_rdata;
  logic                  w_err;
  logic                  w_unused_addr;

  assign w_unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

  assign w_accept = req_valid_i && req_ready_o;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // datapath must see the live request while IDLE and the captured copy after.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_sel_wr       = req_wr_i;
      w_sel_lo       = req_addr_i[1:0];
      w_sel_widx     = req_addr_i[ADDR_WIDTH+1:2];
      w_sel_size     = req_size_i;
      w_sel_unsigned = req_unsigned_i;
      w_sel_wdata    = req_wdata_i;
    end else begin
      w_sel_wr       = r_wr;
      w_sel_lo       = r_lo;
      w_sel_widx     = r_widx;
      w_sel_size     = r_size;
      w_sel_unsigned = r_unsigned;
      w_sel_wdata    = r_wdata;
    end
  end

  assign w_rword = r_mem[w_sel_widx];

  dmem_lane_align u_lane_align (
    .i_addr_lo  (w_sel_lo),
    .i_size     (w_sel_size),
    .i_unsigned (w_sel_unsigned),
    .i_wdata    (w_sel_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_rdata),
    .o_err      (w_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
  assign w_commit     = w_enter_resp && w_sel_wr && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= WAIT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_sel_wr ? '0 : w_rdata;
        r_rsp_err   <= w_err;
      end else if ((r_state == ST_RESP) && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr       <= req_wr_i;
      r_lo       <= req_addr_i[1:0];
      r_widx     <= req_addr_i[ADDR_WIDTH+1:2];
      r_size     <= req_size_i;
      r_unsigned <= req_unsigned_i;
      r_wdata    <= req_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_sel_widx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

endmodule
